// File: rtl/cdc_handshake_rx_ctrl_pkg.sv
// Shared types and defaults for the receive side of the REQ/ACK clock-domain crossing.
package cdc_handshake_rx_ctrl_pkg;

    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned CNT_W_DEF       = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        ACK_HI = 2'd2
    } state_e;

endpackage

// File: rtl/cdc_handshake_rx_ctrl_if.sv
// Crossing bus: source request/data, local valid/ready, and status back out.
interface cdc_handshake_rx_ctrl_if
    import cdc_handshake_rx_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);

    logic              REQ_ASYNC;
    logic [DATA_W-1:0] DATA_ASYNC;
    logic              OUT_READY;
    logic [DATA_W-1:0] OUT_DATA;
    logic              OUT_VALID;
    logic              ACK;
    logic              BUSY;
    logic [CNT_W-1:0]  XFER_CNT;

    // master: source domain plus local consumer; slave: the receive controller
    modport master (
        output REQ_ASYNC, DATA_ASYNC, OUT_READY,
        input  OUT_DATA, OUT_VALID, ACK, BUSY, XFER_CNT
    );

    modport slave (
        input  REQ_ASYNC, DATA_ASYNC, OUT_READY,
        output OUT_DATA, OUT_VALID, ACK, BUSY, XFER_CNT
    );

endinterface

// File: rtl/cdc_handshake_rx_ctrl_sync_chain.sv
// Multi-flop level synchronizer with synchronous active-high clear.
module cdc_handshake_rx_ctrl_sync_chain #(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [NUM_STAGES-1:0] sync_q;
    logic [NUM_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[NUM_STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_handshake_rx_ctrl.sv
// Destination-side 4-phase handshake controller: synchronizes REQ, captures data,
// offers it on valid/ready and returns ACK to the source domain.
module cdc_handshake_rx_ctrl
    import cdc_handshake_rx_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned NUM_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input logic                    CLK,
    input logic                    RST,
    cdc_handshake_rx_ctrl_if.slave bus
);

    logic              req_s;
    state_e            state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;

    cdc_handshake_rx_ctrl_sync_chain #(
        .NUM_STAGES (NUM_STAGES)
    ) u_req_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (bus.REQ_ASYNC),
        .q_o   (req_s)
    );

    // DATA_ASYNC is only sampled in IDLE once req_s is seen, when the source holds it stable.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ack_d       = ack_q;
        xfer_cnt_d  = xfer_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_s) begin
                    out_data_d  = bus.DATA_ASYNC;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                // req_s dropping here is a source violation; the transfer still completes.
                if (bus.OUT_READY) begin
                    out_valid_d = 1'b0;
                    ack_d       = 1'b1;
                    xfer_cnt_d  = xfer_cnt_q + 1'b1;
                    state_d     = ACK_HI;
                end
            end
            ACK_HI: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                ack_d       = 1'b0;
                state_d     = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            xfer_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.ACK       = ack_q;
    assign bus.BUSY      = busy_q;
    assign bus.XFER_CNT  = xfer_cnt_q;

endmodule

// File: tb/tb_cdc_handshake_rx_ctrl.sv
// Self-checking bench for cdc_handshake_rx_ctrl using a data scoreboard queue.
module tb_cdc_handshake_rx_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned NS = 2;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdc_handshake_rx_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    cdc_handshake_rx_ctrl #(
        .DATA_W     (DW),
        .NUM_STAGES (NS),
        .CNT_W      (CW)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] exp_cnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.REQ_ASYNC = 1'b0;
        bus.OUT_READY = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] e;
        rst = 1'b1;
        bus.REQ_ASYNC  = 1'b1;
        bus.DATA_ASYNC = 8'hFF;
        bus.OUT_READY  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({bus.OUT_DATA, bus.OUT_VALID, bus.ACK, bus.BUSY, bus.XFER_CNT} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: data=%0h valid=%0b ack=%0b busy=%0b cnt=%0d want all 0",
                         bus.OUT_DATA, bus.OUT_VALID, bus.ACK, bus.BUSY, bus.XFER_CNT);
            end
        end
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        exp_q.push_back(8'hFF);
        for (int k = 1; k <= NS + 1; k++) begin
            step();
            checks++;
            if (bus.OUT_VALID !== (k == NS + 1)) begin
                failures++;
                $display("FAIL reset_release_latency: edge %0d valid=%0b want %0b",
                         k, bus.OUT_VALID, (k == NS + 1));
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.OUT_DATA !== e) begin
            failures++;
            $display("FAIL reset_release_data: got %0h want %0h", bus.OUT_DATA, e);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] e;
        apply_reset();
        bus.OUT_READY  = 1'b1;
        bus.DATA_ASYNC = 8'hA5;
        bus.REQ_ASYNC  = 1'b1;
        exp_q.push_back(8'hA5);
        repeat (NS + 1) step();
        e = exp_q.pop_front();
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== e || bus.ACK !== 1'b0) begin
            failures++;
            $display("FAIL single_capture: valid=%0b data=%0h ack=%0b want 1 %0h 0",
                     bus.OUT_VALID, bus.OUT_DATA, bus.ACK, e);
        end
        step();
        exp_cnt = exp_cnt + 1'b1;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.ACK !== 1'b1 || bus.XFER_CNT !== exp_cnt ||
            bus.OUT_DATA !== e) begin
            failures++;
            $display("FAIL single_accept: valid=%0b ack=%0b cnt=%0d data=%0h want 0 1 %0d %0h",
                     bus.OUT_VALID, bus.ACK, bus.XFER_CNT, bus.OUT_DATA, exp_cnt, e);
        end
        bus.REQ_ASYNC = 1'b0;
        step();
        checks++;
        if (bus.ACK !== 1'b1) begin
            failures++;
            $display("FAIL single_ack_hold: ack=%0b want 1", bus.ACK);
        end
        repeat (NS) step();
        checks++;
        if (bus.ACK !== 1'b0 || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL single_ack_fall: ack=%0b busy=%0b want 0 0", bus.ACK, bus.BUSY);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] e;
        apply_reset();
        bus.DATA_ASYNC = 8'h3C;
        bus.REQ_ASYNC  = 1'b1;
        exp_q.push_back(8'h3C);
        repeat (NS + 1) step();
        e = exp_q[0];
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== e || bus.ACK !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold: cycle %0d valid=%0b data=%0h ack=%0b want 1 %0h 0",
                         c, bus.OUT_VALID, bus.OUT_DATA, bus.ACK, e);
            end
            step();
        end
        bus.OUT_READY = 1'b1;
        step();
        void'(exp_q.pop_front());
        checks++;
        if (bus.ACK !== 1'b1 || bus.OUT_VALID !== 1'b0 || bus.OUT_DATA !== e) begin
            failures++;
            $display("FAIL backpressure_release: ack=%0b valid=%0b data=%0h want 1 0 %0h",
                     bus.ACK, bus.OUT_VALID, bus.OUT_DATA, e);
        end
        bus.REQ_ASYNC = 1'b0;
        bus.OUT_READY = 1'b0;
        repeat (NS + 1) step();
    endtask

    task automatic test_back_to_back();
        int beats = 0;
        int rises = 0;
        int bad   = 0;
        logic ack_prev = 1'b0;
        apply_reset();
        bus.OUT_READY = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            bus.DATA_ASYNC = 8'(n);
            bus.REQ_ASYNC  = 1'b1;
            exp_q.push_back(8'(n));
            exp_cnt = exp_cnt + 1'b1;
            for (int i = 0; i < 12 && !bus.ACK; i++) begin
                step();
                if (bus.OUT_VALID) begin
                    beats++;
                    if (exp_q.size() == 0 || bus.OUT_DATA !== exp_q[0]) begin
                        bad++;
                        $display("FAIL b2b_data: beat %0d got %0h", beats, bus.OUT_DATA);
                    end
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                if (bus.ACK && !ack_prev) rises++;
                ack_prev = bus.ACK;
            end
            bus.REQ_ASYNC = 1'b0;
            for (int i = 0; i < 12 && bus.ACK; i++) begin
                step();
                ack_prev = bus.ACK;
            end
        end
        checks++;
        if (bad != 0 || beats != 5 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_beats: beats=%0d bad=%0d left=%0d want 5 0 0",
                     beats, bad, exp_q.size());
        end
        checks++;
        if (bus.XFER_CNT !== exp_cnt || rises != 5) begin
            failures++;
            $display("FAIL b2b_count: cnt=%0d rises=%0d want %0d 5", bus.XFER_CNT, rises, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        int errs = 0;
        logic [DW-1:0] d;
        bit seen;
        apply_reset();
        bus.OUT_READY = 1'b1;
        for (int n = 0; n < 256; n++) begin
            d = 8'($urandom);
            bus.DATA_ASYNC = d;
            bus.REQ_ASYNC  = 1'b1;
            exp_q.push_back(d);
            exp_cnt = exp_cnt + 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 12 && !bus.ACK; i++) begin
                step();
                if (bus.OUT_VALID) begin
                    if (bus.OUT_DATA !== exp_q[0]) errs++;
                    void'(exp_q.pop_front());
                    seen = 1'b1;
                end
            end
            if (!seen || !bus.ACK) errs++;
            bus.REQ_ASYNC = 1'b0;
            for (int i = 0; i < 12 && bus.ACK; i++) step();
            if (bus.ACK) errs++;
            if (n == 254) begin
                checks++;
                if (bus.XFER_CNT !== exp_cnt) begin
                    failures++;
                    $display("FAIL wrap_pre: cnt=%0d want %0d", bus.XFER_CNT, exp_cnt);
                end
            end
        end
        checks++;
        if (bus.XFER_CNT !== exp_cnt) begin
            failures++;
            $display("FAIL wrap_cnt: cnt=%0d want %0d", bus.XFER_CNT, exp_cnt);
        end
        checks++;
        if (errs != 0 || bus.OUT_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL wrap_side_effects: errs=%0d valid=%0b busy=%0b want 0 0 0",
                     errs, bus.OUT_VALID, bus.BUSY);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] e;
        apply_reset();
        bus.OUT_READY  = 1'b1;
        bus.DATA_ASYNC = 8'h11;
        bus.REQ_ASYNC  = 1'b1;
        for (int i = 0; i < 12 && !bus.ACK; i++) step();
        bus.REQ_ASYNC = 1'b0;
        for (int i = 0; i < 12 && bus.ACK; i++) step();
        bus.OUT_READY  = 1'b0;
        bus.DATA_ASYNC = 8'h77;
        bus.REQ_ASYNC  = 1'b1;
        exp_q.push_back(8'h77);
        repeat (NS + 1) step();
        e = exp_q.pop_front();
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== e || bus.XFER_CNT !== 8'd1) begin
            failures++;
            $display("FAIL mid_hold: valid=%0b data=%0h cnt=%0d want 1 %0h 1",
                     bus.OUT_VALID, bus.OUT_DATA, bus.XFER_CNT, e);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.ACK !== 1'b0 || bus.BUSY !== 1'b0 ||
            bus.XFER_CNT !== '0) begin
            failures++;
            $display("FAIL mid_reset: valid=%0b ack=%0b busy=%0b cnt=%0d want 0 0 0 0",
                     bus.OUT_VALID, bus.ACK, bus.BUSY, bus.XFER_CNT);
        end
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(8'h77);
        repeat (NS) step();
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL mid_recapture_early: valid=%0b want 0", bus.OUT_VALID);
        end
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== e) begin
            failures++;
            $display("FAIL mid_recapture: valid=%0b data=%0h want 1 %0h",
                     bus.OUT_VALID, bus.OUT_DATA, e);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.REQ_ASYNC  = 1'b0;
        bus.DATA_ASYNC = '0;
        bus.OUT_READY  = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
